// File: rtl/pep_mmacc_body_rd_sched.sv
// Read scheduler in front of the mmacc body RAM.
// Holds in-order body read requests and issues each one to the RAM only once the
// requested PID has its KS body written with the matching parity (and, when
// PEP_MMACC_BORAM_CORR_WAIT_EN is defined, all LWE_K correction writes done).
// Without PEP_MMACC_BORAM_CORR_WAIT_EN the correction counters are removed and the
// correction write port is ignored.
module pep_mmacc_body_rd_sched #(
    parameter int unsigned TOTAL_PBS_NB = 32,
    parameter int unsigned PID_W        = 5,
    parameter int unsigned LWE_K        = 630,
    parameter int unsigned CNT_W        = 10,
    parameter int unsigned REQ_DEPTH    = 8
) (
    input  logic                         clk,
    input  logic                         a_rst_n,
    input  logic                         ks_boram_wr_en,
    input  logic [PID_W-1:0]             ks_boram_wr_pid,
    input  logic                         ks_boram_wr_parity,
    input  logic                         seq_boram_corr_wr_en,
    input  logic [PID_W-1:0]             seq_boram_corr_wr_pid,
    input  logic                         req_vld,
    output logic                         req_rdy,
    input  logic [PID_W-1:0]             req_pid,
    input  logic                         req_parity,
    output logic                         boram_rd_vld,
    input  logic                         boram_rd_rdy,
    output logic [PID_W-1:0]             boram_rd_pid,
    output logic                         boram_rd_parity,
    output logic [$clog2(REQ_DEPTH):0]   sched_pending,
    output logic                         sched_err
);

    localparam int unsigned AW = $clog2(REQ_DEPTH);
    localparam logic [AW:0] FULL_CNT = REQ_DEPTH[AW:0];

    // Request FIFO
    logic [PID_W-1:0] fifo_pid [REQ_DEPTH];
    logic             fifo_par [REQ_DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q, fifo_cnt;
    logic             fifo_full, fifo_empty, push, pop, init_q;

    // Output register and per-PID write progress
    logic                    rd_vld_q, rd_par_q, rd_hs;
    logic [PID_W-1:0]        rd_pid_q;
    logic [TOTAL_PBS_NB-1:0] body_ok_q, body_ok_d, body_par_q, body_par_d;
    logic                    err_q, err_d;
    logic [PID_W-1:0]        head_pid;
    logic                    head_par, head_ready, head_corr_ok, out_wr_hit, corr_ovf;

    assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
    assign fifo_full  = (fifo_cnt == FULL_CNT);
    assign fifo_empty = (fifo_cnt == '0);
    assign req_rdy    = init_q & ~fifo_full;
    assign push       = req_vld & req_rdy;
    assign head_pid   = fifo_pid[rd_ptr_q[AW-1:0]];
    assign head_par   = fifo_par[rd_ptr_q[AW-1:0]];
    assign rd_hs      = rd_vld_q & boram_rd_rdy;

`ifdef PEP_MMACC_BORAM_CORR_WAIT_EN
    logic [CNT_W-1:0] corr_cnt_q [TOTAL_PBS_NB];
    logic [CNT_W-1:0] corr_cnt_d [TOTAL_PBS_NB];
    logic [CNT_W-1:0] corr_base;

    // Correction counters: handshake clears first, then a same-cycle write counts from zero
    always_comb begin
        corr_cnt_d = corr_cnt_q;
        corr_ovf   = 1'b0;
        corr_base  = '0;
        if (rd_hs) corr_cnt_d[rd_pid_q] = '0;
        if (seq_boram_corr_wr_en) begin
            corr_base = corr_cnt_d[seq_boram_corr_wr_pid];
            if (corr_base == CNT_W'(LWE_K)) corr_ovf = 1'b1;
            else corr_cnt_d[seq_boram_corr_wr_pid] = corr_base + CNT_W'(1);
        end
    end

    // Correction counter state
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) corr_cnt_q <= '{default: '0};
        else          corr_cnt_q <= corr_cnt_d;
    end

    assign head_corr_ok = (corr_cnt_q[head_pid] == CNT_W'(LWE_K));
    assign out_wr_hit   = rd_vld_q & ~boram_rd_rdy &
                          ((ks_boram_wr_en & (ks_boram_wr_pid == rd_pid_q)) |
                           (seq_boram_corr_wr_en & (seq_boram_corr_wr_pid == rd_pid_q)));
`else
    logic             unused_corr;
    logic [CNT_W-1:0] unused_lwe;
    assign unused_corr  = ^{seq_boram_corr_wr_en, seq_boram_corr_wr_pid};
    assign unused_lwe   = CNT_W'(LWE_K);
    assign corr_ovf     = 1'b0;
    assign head_corr_ok = 1'b1;
    assign out_wr_hit   = rd_vld_q & ~boram_rd_rdy & ks_boram_wr_en &
                          (ks_boram_wr_pid == rd_pid_q);
`endif

    // Head is ready only against registered state; the PID leaving the output register this
    // cycle still shows stale flags, so it is held back for one cycle
    assign head_ready = body_ok_q[head_pid] & (body_par_q[head_pid] == head_par) & head_corr_ok;
    assign pop        = ~fifo_empty & (~rd_vld_q | rd_hs) & head_ready &
                        ~(rd_hs & (head_pid == rd_pid_q));

    // Body flags: handshake clears, a same-cycle KS write wins
    always_comb begin
        body_ok_d  = body_ok_q;
        body_par_d = body_par_q;
        if (rd_hs) body_ok_d[rd_pid_q] = 1'b0;
        if (ks_boram_wr_en) begin
            body_ok_d[ks_boram_wr_pid]  = 1'b1;
            body_par_d[ks_boram_wr_pid] = ks_boram_wr_parity;
        end
    end

    assign err_d = err_q | corr_ovf | out_wr_hit;

    // Per-PID flags, sticky error and ready-after-reset flag
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            body_ok_q  <= '0;
            body_par_q <= '0;
            err_q      <= 1'b0;
            init_q     <= 1'b0;
        end else begin
            body_ok_q  <= body_ok_d;
            body_par_q <= body_par_d;
            err_q      <= err_d;
            init_q     <= 1'b1;
        end
    end

    // FIFO pointers
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // FIFO storage, no reset needed since pointers gate visibility
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pid[wr_ptr_q[AW-1:0]] <= req_pid;
            fifo_par[wr_ptr_q[AW-1:0]] <= req_parity;
        end
    end

    // Output register: load the ready head, otherwise drop after handshake
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            rd_vld_q <= 1'b0;
            rd_pid_q <= '0;
            rd_par_q <= 1'b0;
        end else if (pop) begin
            rd_vld_q <= 1'b1;
            rd_pid_q <= head_pid;
            rd_par_q <= head_par;
        end else if (rd_hs) begin
            rd_vld_q <= 1'b0;
        end
    end

    assign boram_rd_vld    = rd_vld_q;
    assign boram_rd_pid    = rd_pid_q;
    assign boram_rd_parity = rd_par_q;
    assign sched_pending   = fifo_cnt + {{AW{1'b0}}, rd_vld_q};
    assign sched_err       = err_q;

endmodule

// File: tb/tb_pep_mmacc_body_rd_sched.sv
// Directed bench for pep_mmacc_body_rd_sched; adapts corr-gating expectations to
// PEP_MMACC_BORAM_CORR_WAIT_EN.
module tb_pep_mmacc_body_rd_sched;

    localparam int LWE_K = 630;

    logic       clk = 1'b0;
    logic       a_rst_n = 1'b0;
    logic       ks_boram_wr_en = 1'b0;
    logic [4:0] ks_boram_wr_pid = '0;
    logic       ks_boram_wr_parity = 1'b0;
    logic       seq_boram_corr_wr_en = 1'b0;
    logic [4:0] seq_boram_corr_wr_pid = '0;
    logic       req_vld = 1'b0;
    logic       req_rdy;
    logic [4:0] req_pid = '0;
    logic       req_parity = 1'b0;
    logic       boram_rd_vld;
    logic       boram_rd_rdy = 1'b1;
    logic [4:0] boram_rd_pid;
    logic       boram_rd_parity;
    logic [3:0] sched_pending;
    logic       sched_err;

    int n_total = 0;
    int n_pass  = 0;

    pep_mmacc_body_rd_sched dut (
        .clk                   (clk),
        .a_rst_n               (a_rst_n),
        .ks_boram_wr_en        (ks_boram_wr_en),
        .ks_boram_wr_pid       (ks_boram_wr_pid),
        .ks_boram_wr_parity    (ks_boram_wr_parity),
        .seq_boram_corr_wr_en  (seq_boram_corr_wr_en),
        .seq_boram_corr_wr_pid (seq_boram_corr_wr_pid),
        .req_vld               (req_vld),
        .req_rdy               (req_rdy),
        .req_pid               (req_pid),
        .req_parity            (req_parity),
        .boram_rd_vld          (boram_rd_vld),
        .boram_rd_rdy          (boram_rd_rdy),
        .boram_rd_pid          (boram_rd_pid),
        .boram_rd_parity       (boram_rd_parity),
        .sched_pending         (sched_pending),
        .sched_err             (sched_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic ks_wr(input logic [4:0] pid, input logic par);
        ks_boram_wr_en = 1'b1;
        ks_boram_wr_pid = pid;
        ks_boram_wr_parity = par;
        tick();
        ks_boram_wr_en = 1'b0;
    endtask

    task automatic corr_wr(input logic [4:0] pid, input int n);
        for (int i = 0; i < n; i++) begin
            seq_boram_corr_wr_en = 1'b1;
            seq_boram_corr_wr_pid = pid;
            tick();
        end
        seq_boram_corr_wr_en = 1'b0;
    endtask

    // Body written, plus all corrections when the build waits for them
    task automatic make_ready(input logic [4:0] pid, input logic par);
        ks_wr(pid, par);
`ifdef PEP_MMACC_BORAM_CORR_WAIT_EN
        corr_wr(pid, LWE_K);
`endif
    endtask

    task automatic send_req(input logic [4:0] pid, input logic par);
        chk("req_rdy_before_push", 32'(req_rdy), 32'd1);
        req_vld = 1'b1;
        req_pid = pid;
        req_parity = par;
        tick();
        req_vld = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [4:0] pid,
                           input logic par);
        chk(tag, 32'(boram_rd_vld), 32'(v));
        if (v) begin
            chk(tag, 32'(boram_rd_pid), 32'(pid));
            chk(tag, 32'(boram_rd_parity), 32'(par));
        end
    endtask

    initial begin
        // Reset values
        #3;
        chk("rst_req_rdy", 32'(req_rdy), 32'd0);
        chk("rst_vld", 32'(boram_rd_vld), 32'd0);
        chk("rst_pending", 32'(sched_pending), 32'd0);
        chk("rst_err", 32'(sched_err), 32'd0);
        tick();
        a_rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_req_rdy", 32'(req_rdy), 32'd1);

        // Ready before request: vld two cycles after acceptance
        make_ready(5'd3, 1'b1);
        send_req(5'd3, 1'b1);
        chk_out("rdy_first_n1", 1'b0, 5'd0, 1'b0);
        chk("rdy_first_pend", 32'(sched_pending), 32'd1);
        tick();
        chk_out("rdy_first_n2", 1'b1, 5'd3, 1'b1);
        tick();
        chk_out("rdy_first_done", 1'b0, 5'd0, 1'b0);
        chk("rdy_first_pend0", 32'(sched_pending), 32'd0);

        // Parity gating
        make_ready(5'd5, 1'b0);
        send_req(5'd5, 1'b1);
        tick();
        tick();
        chk_out("par_gate_wait", 1'b0, 5'd0, 1'b0);
        ks_wr(5'd5, 1'b1);
        chk_out("par_gate_m1", 1'b0, 5'd0, 1'b0);
        tick();
        chk_out("par_gate_m2", 1'b1, 5'd5, 1'b1);
        tick();
        chk_out("par_gate_done", 1'b0, 5'd0, 1'b0);

        // Correction gating
        ks_wr(5'd7, 1'b0);
`ifdef PEP_MMACC_BORAM_CORR_WAIT_EN
        corr_wr(5'd7, LWE_K - 1);
        send_req(5'd7, 1'b0);
        tick();
        tick();
        chk_out("corr_gate_629", 1'b0, 5'd0, 1'b0);
        corr_wr(5'd7, 1);
        chk_out("corr_gate_k1", 1'b0, 5'd0, 1'b0);
        tick();
        chk_out("corr_gate_k2", 1'b1, 5'd7, 1'b0);
`else
        send_req(5'd7, 1'b0);
        chk_out("nocorr_n1", 1'b0, 5'd0, 1'b0);
        tick();
        chk_out("nocorr_n2", 1'b1, 5'd7, 1'b0);
`endif
        tick();
        chk_out("corr_gate_done", 1'b0, 5'd0, 1'b0);

        // In-order: pid4 ready behind a blocked pid2
        send_req(5'd2, 1'b0);
        send_req(5'd4, 1'b0);
        make_ready(5'd4, 1'b0);
        tick();
        tick();
        chk_out("inorder_blocked", 1'b0, 5'd0, 1'b0);
        chk("inorder_pend", 32'(sched_pending), 32'd2);
        make_ready(5'd2, 1'b0);
        chk_out("inorder_m1", 1'b0, 5'd0, 1'b0);
        tick();
        chk_out("inorder_pid2", 1'b1, 5'd2, 1'b0);
        tick();
        chk_out("inorder_pid4", 1'b1, 5'd4, 1'b0);
        tick();
        chk_out("inorder_done", 1'b0, 5'd0, 1'b0);

        // Backpressure: output held stable, FIFO fills up
        boram_rd_rdy = 1'b0;
        make_ready(5'd6, 1'b1);
        send_req(5'd6, 1'b1);
        tick();
        for (int i = 0; i < 10; i++) begin
            chk_out("bp_stable", 1'b1, 5'd6, 1'b1);
            tick();
        end
        for (int i = 0; i < 8; i++) send_req(5'(8 + i), 1'b0);
        chk("bp_req_rdy", 32'(req_rdy), 32'd0);
        chk("bp_pending", 32'(sched_pending), 32'd9);
        chk_out("bp_still", 1'b1, 5'd6, 1'b1);
        boram_rd_rdy = 1'b1;
        tick();
        chk_out("bp_drained", 1'b0, 5'd0, 1'b0);
        chk("bp_pending8", 32'(sched_pending), 32'd8);

        // Correction overflow on pid1
        corr_wr(5'd1, LWE_K);
        chk("ovf_none_yet", 32'(sched_err), 32'd0);
        corr_wr(5'd1, 1);
`ifdef PEP_MMACC_BORAM_CORR_WAIT_EN
        chk("ovf_err", 32'(sched_err), 32'd1);
        tick();
        tick();
        chk("ovf_sticky", 32'(sched_err), 32'd1);
        chk("ovf_cnt_sat", 32'(dut.corr_cnt_q[1]), 32'(LWE_K));
`else
        tick();
        chk("nocorr_no_err", 32'(sched_err), 32'd0);
`endif

        // Reset pulse mid-operation flushes everything
        a_rst_n = 1'b0;
        #1;
        chk("rst2_err", 32'(sched_err), 32'd0);
        chk("rst2_pending", 32'(sched_pending), 32'd0);
        chk("rst2_req_rdy", 32'(req_rdy), 32'd0);
        tick();
        a_rst_n = 1'b1;
        tick();
        chk("rst2_req_rdy_after", 32'(req_rdy), 32'd1);
        chk_out("rst2_vld", 1'b0, 5'd0, 1'b0);

        // Same pid twice: second must not issue on stale flags
        make_ready(5'd10, 1'b0);
        send_req(5'd10, 1'b0);
        send_req(5'd10, 1'b0);
        chk_out("dup_first", 1'b1, 5'd10, 1'b0);
        tick();
        chk_out("dup_hold1", 1'b0, 5'd0, 1'b0);
        tick();
        chk_out("dup_hold2", 1'b0, 5'd0, 1'b0);
        chk("dup_pending", 32'(sched_pending), 32'd1);
        make_ready(5'd10, 1'b0);
        tick();
        chk_out("dup_second", 1'b1, 5'd10, 1'b0);
        tick();
        chk("dup_pending0", 32'(sched_pending), 32'd0);

        // KS write to the pid stalled in the output register
        boram_rd_rdy = 1'b0;
        make_ready(5'd9, 1'b0);
        send_req(5'd9, 1'b0);
        tick();
        chk_out("owr_vld", 1'b1, 5'd9, 1'b0);
        chk("owr_err_before", 32'(sched_err), 32'd0);
        ks_wr(5'd9, 1'b1);
        chk("owr_err", 32'(sched_err), 32'd1);
        boram_rd_rdy = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
